// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 store path: size encodings, store FSM
// states and the default bus-write timeout.
package msrv32_pkg;

  typedef enum logic [1:0] {
    SZ_SB  = 2'b00,
    SZ_SH  = 2'b01,
    SZ_SW  = 2'b10,
    SZ_ILL = 2'b11
  } store_size_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } store_state_e;

  localparam int STORE_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/msrv32_store_unit_if.sv
// Data-memory write bus between the store unit (master) and memory (slave).
interface msrv32_store_unit_if;

  logic [31:0] ms_riscv32_mp_dmaddr_out;
  logic [31:0] ms_riscv32_mp_dmdata_out;
  logic [3:0]  ms_riscv32_mp_dmwr_mask_out;
  logic        ms_riscv32_mp_dmwr_req_out;
  logic        ms_riscv32_mp_dmwr_ready_in;

  modport master (
    output ms_riscv32_mp_dmaddr_out,
    output ms_riscv32_mp_dmdata_out,
    output ms_riscv32_mp_dmwr_mask_out,
    output ms_riscv32_mp_dmwr_req_out,
    input  ms_riscv32_mp_dmwr_ready_in
  );

  modport slave (
    input  ms_riscv32_mp_dmaddr_out,
    input  ms_riscv32_mp_dmdata_out,
    input  ms_riscv32_mp_dmwr_mask_out,
    input  ms_riscv32_mp_dmwr_req_out,
    output ms_riscv32_mp_dmwr_ready_in
  );

endinterface

// File: rtl/msrv32_store_lane_align.sv
// Combinational byte-lane placement, byte-enable generation and alignment
// check for SB/SH/SW stores.
module msrv32_store_lane_align
  import msrv32_pkg::*;
(
  input  logic [1:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] data_o,
  output logic [3:0]  mask_o,
  output logic        misaligned_o
);

  always_comb begin
    data_o       = rs2_i;
    mask_o       = 4'b0000;
    misaligned_o = 1'b0;
    case (store_size_e'(funct3_i))
      SZ_SB: begin
        data_o = {4{rs2_i[7:0]}};
        mask_o = 4'b0001 << addr_lo_i;
      end
      SZ_SH: begin
        data_o       = {2{rs2_i[15:0]}};
        mask_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misaligned_o = addr_lo_i[0];
      end
      SZ_SW: begin
        mask_o       = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      SZ_ILL: begin
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_store_unit.sv
// Store unit: accepts one aligned store at a time, holds it on the data bus
// until ready, and aborts it if ready does not arrive within TIMEOUT_CYCLES.
module msrv32_store_unit
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = STORE_TIMEOUT_DEFAULT
) (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_in,
  input  logic                       mem_wr_req_in,
  input  logic [1:0]                 funct3_in,
  input  logic [31:0]                iadder_in,
  input  logic [31:0]                rs2_in,
  msrv32_store_unit_if.master        bus,
  output logic                       store_busy_out,
  output logic                       store_done_out,
  output logic                       misaligned_store_out,
  output logic                       store_err_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  store_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [3:0]    mask_q;
  logic          req_q;
  logic          done_q;
  logic          err_q;
  logic          mis_q;

  logic [31:0]   lane_data;
  logic [3:0]    lane_mask;
  logic          lane_misaligned;

  msrv32_store_lane_align u_lane_align (
    .funct3_i     (funct3_in),
    .addr_lo_i    (iadder_in[1:0]),
    .rs2_i        (rs2_in),
    .data_o       (lane_data),
    .mask_o       (lane_mask),
    .misaligned_o (lane_misaligned)
  );

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_wr_req_in) begin
            if (lane_misaligned) begin
              mis_q <= 1'b1;
            end else begin
              addr_q  <= {iadder_in[31:2], 2'b00};
              data_q  <= lane_data;
              mask_q  <= lane_mask;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_PENDING;
            end
          end
        end
        ST_PENDING: begin
          // Ready is checked first so a ready in the timeout cycle still completes.
          if (bus.ms_riscv32_mp_dmwr_ready_in) begin
            done_q  <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
      endcase
    end
  end

  assign bus.ms_riscv32_mp_dmaddr_out    = addr_q;
  assign bus.ms_riscv32_mp_dmdata_out    = data_q;
  assign bus.ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign bus.ms_riscv32_mp_dmwr_req_out  = req_q;
  assign store_busy_out                  = (state_q == ST_PENDING);
  assign store_done_out                  = done_q;
  assign misaligned_store_out            = mis_q;
  assign store_err_out                   = err_q;

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Randomized and directed bench for msrv32_store_unit: dut_a uses the default
// timeout, dut_b a timeout of 4; a behavioural model predicts every output.
module tb_msrv32_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rdy;
  logic        sel;
  logic [1:0]  f3;
  logic [31:0] addr;
  logic [31:0] rs2;

  logic busy_a, done_a, mis_a, err_a;
  logic busy_b, done_b, mis_b, err_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  msrv32_store_unit_if bus_a ();
  msrv32_store_unit_if bus_b ();

  assign bus_a.ms_riscv32_mp_dmwr_ready_in = rdy & ~sel;
  assign bus_b.ms_riscv32_mp_dmwr_ready_in = rdy & sel;

  msrv32_store_unit #(.TIMEOUT_CYCLES(255)) dut_a (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .mem_wr_req_in        (req),
    .funct3_in            (f3),
    .iadder_in            (addr),
    .rs2_in               (rs2),
    .bus                  (bus_a),
    .store_busy_out       (busy_a),
    .store_done_out       (done_a),
    .misaligned_store_out (mis_a),
    .store_err_out        (err_a)
  );

  msrv32_store_unit #(.TIMEOUT_CYCLES(4)) dut_b (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .mem_wr_req_in        (req),
    .funct3_in            (f3),
    .iadder_in            (addr),
    .rs2_in               (rs2),
    .bus                  (bus_b),
    .store_busy_out       (busy_b),
    .store_done_out       (done_b),
    .misaligned_store_out (mis_b),
    .store_err_out        (err_b)
  );

  // Observation view of whichever DUT is currently selected.
  logic [31:0] o_addr, o_data;
  logic [3:0]  o_mask;
  logic        o_req, o_busy, o_done, o_mis, o_err;
  assign o_addr = sel ? bus_b.ms_riscv32_mp_dmaddr_out    : bus_a.ms_riscv32_mp_dmaddr_out;
  assign o_data = sel ? bus_b.ms_riscv32_mp_dmdata_out    : bus_a.ms_riscv32_mp_dmdata_out;
  assign o_mask = sel ? bus_b.ms_riscv32_mp_dmwr_mask_out : bus_a.ms_riscv32_mp_dmwr_mask_out;
  assign o_req  = sel ? bus_b.ms_riscv32_mp_dmwr_req_out  : bus_a.ms_riscv32_mp_dmwr_req_out;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_mis  = sel ? mis_b  : mis_a;
  assign o_err  = sel ? err_b  : err_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: size in bytes is 2**funct3; an access is aligned when the
  // address is a multiple of its size; 3 is an illegal size.
  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] m_data(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d % 32'h100) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 32'h1_0000) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] m_mask(input logic [1:0] sz, input logic [31:0] a);
    int m;
    if (sz == 2'd0) m = 1 << (a % 4);
    else if (sz == 2'd1) m = 3 << (a % 4);
    else m = 15;
    return m[3:0];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, o_addr, 32'h0);
    chk({tag, "_data"}, o_data, 32'h0);
    chk({tag, "_mask"}, {28'h0, o_mask}, 32'h0);
    chk({tag, "_ctl"}, {27'h0, o_req, o_busy, o_done, o_mis, o_err}, 32'h0);
  endtask

  // One store on the selected DUT; ready rises on the delay-th pending cycle.
  task automatic run_store(input bit use_b, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input int delay, input bit intrude);
    int tmo;
    bit fin;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_mask;
    tmo    = use_b ? 4 : 255;
    e_addr = a - (a % 4);
    e_data = m_data(sz, d);
    e_mask = m_mask(sz, a);
    sel  = use_b;
    req  = 1'b1;
    f3   = sz;
    addr = a;
    rs2  = d;
    rdy  = 1'($urandom_range(0, 1));
    tick();
    req = 1'b0;
    rdy = 1'b0;
    $display("store dut=%s size=%0d addr=%h rs2=%h delay=%0d intrude=%0d", use_b ? "b" : "a",
             sz, a, d, delay, intrude);
    if (m_misaligned(sz, a)) begin
      chk("mis_pulse", {29'h0, o_mis, o_req, o_busy}, 32'h4);
      tick();
      chk("mis_clear", {29'h0, o_mis, o_req, o_busy}, 32'h0);
      return;
    end
    fin = 1'b0;
    for (int w = 0; w < tmo && !fin; w++) begin
      chk("pend_addr", o_addr, e_addr);
      chk("pend_data", o_data, e_data);
      chk("pend_mask", {28'h0, o_mask}, {28'h0, e_mask});
      chk("pend_ctl", {27'h0, o_req, o_busy, o_done, o_mis, o_err}, 32'h18);
      if (intrude) begin
        req  = 1'b1;
        f3   = 2'($urandom_range(0, 3));
        addr = $urandom;
        rs2  = $urandom;
      end
      rdy = (w == delay);
      fin = rdy;
      tick();
    end
    req = 1'b0;
    rdy = 1'b0;
    chk("end_done", {31'h0, o_done}, {31'h0, delay < tmo});
    chk("end_err", {31'h0, o_err}, {31'h0, delay >= tmo});
    chk("end_idle", {29'h0, o_req, o_busy, o_mis}, 32'h0);
    tick();
    chk("pulse_clear", {30'h0, o_done, o_err}, 32'h0);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 1'b0;
    rdy  = 1'b0;
    sel  = 1'b0;
    f3   = 2'd0;
    addr = 32'h0;
    rs2  = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all_zero("reset_a");
    sel = 1'b1;
    #0;
    chk_all_zero("reset_b");
    sel = 1'b0;

    // Ready while idle has no effect.
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready", {29'h0, o_req, o_busy, o_done}, 32'h0);
    end
    rdy = 1'b0;

    run_store(1'b0, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF, 0, 1'b0);
    run_store(1'b0, 2'd0, 32'h1000_0003, 32'h0000_00A5, 0, 1'b0);
    run_store(1'b0, 2'd1, 32'h1000_0002, 32'h0000_1234, 0, 1'b0);
    run_store(1'b0, 2'd1, 32'h1000_0001, 32'h0000_1234, 0, 1'b0);
    run_store(1'b0, 2'd3, 32'h1000_0000, 32'h5555_AAAA, 0, 1'b0);
    run_store(1'b0, 2'd2, 32'h2000_0010, 32'hCAFE_F00D, 5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rsz;
      logic [31:0] ra;
      rsz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ra  = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rsz) - 1);
      run_store(1'b0, rsz, ra, $urandom, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a pending write.
    sel  = 1'b0;
    req  = 1'b1;
    f3   = 2'd2;
    addr = 32'h3000_0008;
    rs2  = 32'h1111_2222;
    tick();
    req = 1'b0;
    tick();
    chk("pre_reset_busy", {31'h0, o_busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("mid_reset");
    tick();
    chk("post_reset_pulses", {29'h0, o_req, o_done, o_err}, 32'h0);
    run_store(1'b0, 2'd2, 32'h3000_000C, 32'h0BAD_CAFE, 1, 1'b0);

    // Timeout checks on the short-timeout instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_store(1'b1, 2'd2, 32'h4000_0000, 32'h7777_8888, 100, 1'b0);
    run_store(1'b1, 2'd0, 32'h4000_0001, 32'h0000_0042, 3, 1'b0);
    run_store(1'b1, 2'd1, 32'h4000_0006, 32'h0000_BEEF, 4, 1'b1);
    run_store(1'b1, 2'd2, 32'h4000_0008, 32'h0102_0304, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
